// File: rtl/data_sram_responder_pkg.sv
`default_nettype none
// data_sram_responder_pkg: shared size encodings and response-queue entry layout. Rev 1.0
package data_sram_responder_pkg;

  localparam logic [1:0] DSRAM_SIZE_B = 2'd0;
  localparam logic [1:0] DSRAM_SIZE_H = 2'd1;
  localparam logic [1:0] DSRAM_SIZE_W = 2'd2;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic              is_wr;
    logic [DATA_W-1:0] data;
  } resp_entry_t;

  function automatic logic size_is_legal(input logic [1:0] size);
    return (size == DSRAM_SIZE_B) || (size == DSRAM_SIZE_H) || (size == DSRAM_SIZE_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_responder_bram_be_sp.sv
`default_nettype none
// bram_be_sp: single-port word RAM, byte-lane write enables, registered read-before-write. Rev 1.0
module bram_be_sp
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int WORDS = 2 ** ADDR_W;

  // One narrow array per lane keeps each byte an independent write port.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[i]) begin
          mem[addr] <= wdata[8*i +: 8];
        end
        lane_q <= mem[addr];
      end
    end

    assign rdata[8*i +: 8] = lane_q;
  end

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// data_sram_responder: in-order fixed-latency slave for the CPU data-SRAM port. Rev 1.0
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  resp_entry_t       q [DEPTH];
  resp_entry_t       head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  load_ptr;
  logic [PTR_W:0]    count;
  logic              load_pend;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_ok;

  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign data_sram_addr_ok = (count < FULL_CNT) && !reset;
  assign push              = data_sram_req && data_sram_addr_ok;
  assign ram_we            = data_sram_wr ? data_sram_wstrb : 4'b0000;
  assign head              = q[rd_ptr];
  assign data_sram_data_ok = !reset && (count != '0) && (head.cnt == '0);
  assign pop               = data_sram_data_ok;

  assign unused_ok = ^{size_is_legal(data_sram_size), data_sram_addr[31:ADDR_W+2],
                       data_sram_addr[1:0]};

  bram_be_sp #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (push),
    .we   (ram_we),
    .addr (idx),
    .wdata(data_sram_wdata),
    .rdata(ram_rdata)
  );

  // Load data lands in the RAM output register one cycle after acceptance;
  // forward it when the freshly pushed load is already the responding head.
  always_comb begin
    data_sram_rdata = '0;
    if (data_sram_data_ok && !head.is_wr) begin
      data_sram_rdata = (load_pend && (load_ptr == rd_ptr)) ? ram_rdata : head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      load_ptr  <= '0;
      count     <= '0;
      load_pend <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].cnt != '0) begin
          q[i].cnt <= q[i].cnt - CNT_W'(1);
        end
      end
      if (load_pend) begin
        q[load_ptr].data <= ram_rdata;
      end
      if (push) begin
        q[wr_ptr] <= '{cnt: CNT_INIT, is_wr: data_sram_wr, data: '0};
        wr_ptr    <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      load_pend <= push && !data_sram_wr;
      load_ptr  <= wr_ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// tb_data_sram_responder: two responders (latency 1 and 3) on shared stimulus, scored against a queue model.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  aok;
  logic [1:0]  dok;
  logic [1:0][31:0] rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .LATENCY(1), .DEPTH(2)) dut_l1 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
    .data_sram_rdata(rd[0])
  );

  data_sram_responder #(.ADDR_W(10), .LATENCY(3), .DEPTH(2)) dut_l3 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
    .data_sram_rdata(rd[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each DUT is an in-order list of responses, each due
  // exactly LATENCY cycles after acceptance, with at most DEPTH outstanding.
  typedef struct {
    int          due;
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        mq [2][$];
  logic [31:0] mmem [2][16];
  int          lat [2] = '{1, 3};
  int          cyc = 0;
  logic        e_aok;
  logic        e_dok;
  logic [31:0] e_rd;
  logic [3:0]  widx;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      e_aok = !reset && (mq[k].size() < 2);
      e_dok = 1'b0;
      e_rd  = '0;
      if (!reset && mq[k].size() > 0) begin
        if (mq[k][0].due == cyc) begin
          e_dok = 1'b1;
          e_rd  = mq[k][0].is_wr ? 32'h0 : mq[k][0].data;
        end
      end
      chk($sformatf("model dut%0d addr_ok c%0d", k, cyc), {31'b0, aok[k]}, {31'b0, e_aok});
      chk($sformatf("model dut%0d data_ok c%0d", k, cyc), {31'b0, dok[k]}, {31'b0, e_dok});
      chk($sformatf("model dut%0d rdata c%0d", k, cyc), rd[k], e_rd);
      if (reset) begin
        mq[k].delete();
      end else begin
        if (e_dok) void'(mq[k].pop_front());
        if (req && e_aok) begin
          widx = addr[5:2];
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) mmem[k][widx][8*b +: 8] = wdata[8*b +: 8];
            end
            mq[k].push_back('{due: cyc + lat[k], is_wr: 1'b1, data: 32'h0});
          end else begin
            mq[k].push_back('{due: cyc + lat[k], is_wr: 1'b0, data: mmem[k][widx]});
          end
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  logic [0:9]  pat_aok = 10'b1100110011;
  logic [0:9]  pat_dok = 10'b0001100110;
  logic [31:0] l4_addr [4] = '{32'h20, 32'h24, 32'h28, 32'h2C};
  logic [31:0] l4_data [4] = '{32'hCAFEBABE, 32'hDEADBEEF, 32'h0BADF00D, 32'h13579BDF};
  int          acc;
  int          resp;
  logic [31:0] a;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hA1B2C3D4, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'hA1B2C3D4};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0013, 4'b1000, 32'h5A000000, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'h5A223344};
    vecs[5]  = '{1'b0, 32'hABCD_E013, 4'b0000, 32'h0,        32'h5A223344};
    vecs[6]  = '{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0011, 4'b0000, 32'h0,        32'h5A223344};
    vecs[8]  = '{1'b1, 32'hFFFF_F010, 4'b0011, 32'h0000BEEF, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'h5A22BEEF};
    vecs[10] = '{1'b1, 32'h0000_0014, 4'b1111, 32'h00000000, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0014, 4'b0101, 32'h12345678, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0014, 4'b0000, 32'h0,        32'h00340078};

    // Reset held three cycles with a request pending.
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    repeat (3) begin
      @(negedge clk);
      chk("reset addr_ok", {30'b0, aok}, 32'h0);
      chk("reset data_ok", {30'b0, dok}, 32'h0);
      chk("reset rdata l1", rd[0], 32'h0);
      chk("reset rdata l3", rd[1], 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post-reset addr_ok", {30'b0, aok}, 32'h3);
    @(posedge clk); #1;

    // Give every word the bench touches a known value.
    for (int w = 0; w < 16; w++) begin
      issue(1'b1, w * 4, 4'b1111, $urandom);
      idle(3);
    end

    // Isolated requests with hand-derived latency-1 responses.
    for (int v = 0; v < 13; v++) begin
      issue(vecs[v].wr, vecs[v].addr, vecs[v].wstrb, vecs[v].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d data_ok", v), {31'b0, dok[0]}, 32'h1);
      chk($sformatf("vec%0d rdata", v), rd[0], vecs[v].exp);
      idle(3);
    end

    // Store then load back-to-back at latency 1.
    req = 1'b1; wr = 1'b1; addr = 32'h20; wstrb = 4'b1111; wdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("b2b store data_ok", {31'b0, dok[0]}, 32'h1);
    chk("b2b store rdata", rd[0], 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("b2b load data_ok", {31'b0, dok[0]}, 32'h1);
    chk("b2b load rdata", rd[0], 32'hCAFEBABE);
    idle(4);

    for (int i = 1; i < 4; i++) begin
      issue(1'b1, l4_addr[i], 4'b1111, l4_data[i]);
      idle(3);
    end

    // Latency 3, depth 2: four loads with request held until accepted.
    acc = 0; resp = 0;
    req = 1'b1; wr = 1'b0; addr = l4_addr[0];
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("fill addr_ok c%0d", j), {31'b0, aok[1]}, {31'b0, pat_aok[j]});
      chk($sformatf("fill data_ok c%0d", j), {31'b0, dok[1]}, {31'b0, pat_dok[j]});
      if (dok[1] && resp < 4) begin
        chk($sformatf("fill rdata r%0d", resp), rd[1], l4_data[resp]);
        resp++;
      end
      if (req && aok[1]) acc++;
      @(posedge clk); #1;
      if (acc >= 4) req = 1'b0;
      else addr = l4_addr[acc];
    end
    chk("fill response count", resp, 4);
    idle(4);

    // Eight back-to-back loads at latency 1: no bubbles.
    for (int j = 0; j < 9; j++) begin
      req = (j < 8); wr = 1'b0; addr = (j % 16) * 4;
      @(negedge clk);
      chk($sformatf("stream addr_ok c%0d", j), {31'b0, aok[0]}, 32'h1);
      chk($sformatf("stream data_ok c%0d", j), {31'b0, dok[0]}, (j >= 1) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
    end
    req = 1'b0;
    idle(4);

    // Reset with loads outstanding; the earlier store must survive.
    issue(1'b1, 32'h30, 4'b1111, 32'h0F0F1234);
    idle(3);
    req = 1'b1; wr = 1'b0; addr = 32'h30;
    @(posedge clk); #1;
    addr = 32'h34;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("after reset data_ok", {30'b0, dok}, 32'h0);
    end
    @(posedge clk); #1;
    issue(1'b0, 32'h30, 4'b0000, 32'h0);
    @(negedge clk);
    chk("kept store l1 data_ok", {31'b0, dok[0]}, 32'h1);
    chk("kept store l1 rdata", rd[0], 32'h0F0F1234);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("kept store l3 data_ok", {31'b0, dok[1]}, 32'h1);
    chk("kept store l3 rdata", rd[1], 32'h0F0F1234);
    @(posedge clk); #1;
    idle(4);

    // Random traffic over 16 words with aliased upper/low address bits.
    for (int j = 0; j < 600; j++) begin
      a = $urandom;
      a[11:6] = 6'b0;
      req   = ($urandom_range(0, 9) < 7);
      wr    = $urandom_range(0, 1);
      addr  = a;
      size  = 2'($urandom_range(0, 2));
      wstrb = 4'($urandom);
      wdata = $urandom;
      reset = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    req = 1'b0; reset = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
